// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - packs three UART bytes into a 24-bit command word with timeout and overrun flags
module uart_cmd_assembler #(
  parameter int TMO_CYC = 52080,
  parameter int TMO_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_rdy,
  output logic        o_rx_clr_rdy,
  input  logic        i_clr_cmd_rdy,
  output logic [23:0] o_cmd,
  output logic        o_cmd_rdy,
  output logic        o_ovr,
  output logic        o_tmo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GOT1 = 2'd1,
    S_GOT2 = 2'd2
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_hi_byte;
  logic [7:0]       r_mid_byte;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [23:0]      r_cmd;
  logic             r_cmd_rdy;
  logic             r_ovr;
  logic             r_tmo;

  logic             w_accept;
  logic             w_complete;
  logic             w_timeout;

  // The block never stalls the receiver, so every presented byte is taken.
  assign w_accept     = i_rx_rdy;
  assign o_rx_clr_rdy = i_rx_rdy;

  // A frame completes on the third byte; a partial frame expires only when no byte arrives.
  assign w_complete = (r_state == S_GOT2) && w_accept;
  assign w_timeout  = (r_state != S_IDLE) && !w_accept && (r_tmo_cnt == TMO_LAST);

  // Frame position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next frame position: advance per accepted byte, fall back to IDLE on timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_GOT1;
      S_GOT1: begin
        if (w_accept)       w_next_state = S_GOT2;
        else if (w_timeout) w_next_state = S_IDLE;
      end
      S_GOT2: begin
        if (w_accept)       w_next_state = S_IDLE;
        else if (w_timeout) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Hold the first two bytes of the frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_byte  <= 8'h00;
      r_mid_byte <= 8'h00;
    end else if (w_accept) begin
      if (r_state == S_IDLE) r_hi_byte  <= i_rx_data;
      if (r_state == S_GOT1) r_mid_byte <= i_rx_data;
    end
  end

  // Inter-byte gap counter; runs only while a partial frame is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_accept || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Command word, ready/overrun handshake and timeout pulse; completion beats acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd     <= 24'h000000;
      r_cmd_rdy <= 1'b0;
      r_ovr     <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_tmo <= w_timeout;
      if (w_complete) begin
        r_cmd     <= {r_hi_byte, r_mid_byte, i_rx_data};
        r_cmd_rdy <= 1'b1;
        if (r_cmd_rdy && !i_clr_cmd_rdy) begin
          r_ovr <= 1'b1;
        end else if (i_clr_cmd_rdy) begin
          r_ovr <= 1'b0;
        end
      end else if (i_clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
        r_ovr     <= 1'b0;
      end
    end
  end

  assign o_cmd     = r_cmd;
  assign o_cmd_rdy = r_cmd_rdy;
  assign o_ovr     = r_ovr;
  assign o_tmo     = r_tmo;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb/tb_uart_cmd_assembler.sv - directed and randomized checks of uart_cmd_assembler against a frame-level model
module tb_uart_cmd_assembler;

  localparam int TMO_CYC = 64;
  localparam int TMO_W   = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_clr_rdy;
  logic        clr_cmd_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        ovr;
  logic        tmo;

  int checks;
  int errors;
  int tmo_seen;

  // Reference model state: bytes of the frame in progress, idle cycles since its last byte.
  logic [7:0]  m_frame[$];
  int          m_gap;
  logic [23:0] m_cmd;
  logic        m_cmd_rdy;
  logic        m_ovr;
  logic        m_tmo;

  uart_cmd_assembler #(.TMO_CYC(TMO_CYC), .TMO_W(TMO_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_rdy     (rx_rdy),
    .o_rx_clr_rdy (rx_clr_rdy),
    .i_clr_cmd_rdy(clr_cmd_rdy),
    .o_cmd        (cmd),
    .o_cmd_rdy    (cmd_rdy),
    .o_ovr        (ovr),
    .o_tmo        (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_gap     = 0;
    m_cmd     = 24'h0;
    m_cmd_rdy = 1'b0;
    m_ovr     = 1'b0;
    m_tmo     = 1'b0;
  endtask

  // What one clock edge must do, phrased in terms of frames and handshakes.
  task automatic model_step(input logic acc, input logic [7:0] d, input logic clr);
    m_tmo = 1'b0;
    if (acc) begin
      m_frame.push_back(d);
      m_gap = 0;
      if (m_frame.size() == 3) begin
        m_cmd = {m_frame[0], m_frame[1], m_frame[2]};
        m_frame.delete();
        if (m_cmd_rdy && !clr) m_ovr = 1'b1;
        else if (clr)          m_ovr = 1'b0;
        m_cmd_rdy = 1'b1;
      end else if (clr) begin
        m_cmd_rdy = 1'b0;
        m_ovr     = 1'b0;
      end
    end else begin
      if (clr) begin
        m_cmd_rdy = 1'b0;
        m_ovr     = 1'b0;
      end
      if (m_frame.size() != 0) begin
        m_gap++;
        if (m_gap == TMO_CYC) begin
          m_frame.delete();
          m_gap = 0;
          m_tmo = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("cmd", {8'h0, cmd}, {8'h0, m_cmd});
    check("cmd_rdy", {31'h0, cmd_rdy}, {31'h0, m_cmd_rdy});
    check("ovr", {31'h0, ovr}, {31'h0, m_ovr});
    check("tmo", {31'h0, tmo}, {31'h0, m_tmo});
  endtask

  // One clock: inputs applied at negedge, ack checked combinationally, outputs checked next negedge.
  task automatic cycle(input logic acc, input logic [7:0] d, input logic clr);
    rx_rdy      = acc;
    rx_data     = acc ? d : $urandom_range(0, 255);
    clr_cmd_rdy = clr;
    #1;
    check("rx_clr_rdy", {31'h0, rx_clr_rdy}, {31'h0, acc});
    @(posedge clk);
    model_step(acc, d, clr);
    @(negedge clk);
    if (tmo) tmo_seen++;
    check_outputs();
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, d, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    rst_n       = 1'b0;
    #1;
    model_reset();
    check("rst_cmd", {8'h0, cmd}, 32'h0);
    check("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("rst_ovr", {31'h0, ovr}, 32'h0);
    check("rst_tmo", {31'h0, tmo}, 32'h0);
    check("rst_rx_clr_rdy", {31'h0, rx_clr_rdy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    tmo_seen    = 0;
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
    model_reset();
    do_reset();

    // Widely spaced bytes stay inside the timeout window.
    send(8'hA5); idle(TMO_CYC - 2);
    send(8'h12); idle(TMO_CYC - 2);
    send(8'h34);
    check("t1_cmd", {8'h0, cmd}, 32'h00A51234);
    check("t1_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
    check("t1_no_tmo", tmo_seen, 0);
    cycle(1'b0, 8'h00, 1'b1);

    // Partial frame abandoned, then a fresh frame.
    send(8'h01); send(8'h02);
    idle(TMO_CYC);
    check("t2_tmo_count", tmo_seen, 1);
    send(8'h03); send(8'h04); send(8'h05);
    check("t2_cmd", {8'h0, cmd}, 32'h00030405);
    check("t2_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
    cycle(1'b0, 8'h00, 1'b1);

    // Overrun from two unacknowledged frames, then acknowledge.
    repeat (3) send(8'h11);
    repeat (3) send(8'h22);
    check("t3_cmd", {8'h0, cmd}, 32'h00222222);
    check("t3_ovr", {31'h0, ovr}, 32'h1);
    cycle(1'b0, 8'h00, 1'b1);
    check("t3_ack_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("t3_ack_ovr", {31'h0, ovr}, 32'h0);
    check("t3_ack_cmd", {8'h0, cmd}, 32'h00222222);

    // Completion coinciding with acknowledge of a pending command.
    repeat (3) send(8'h33);
    send(8'h44); send(8'h55);
    cycle(1'b1, 8'h66, 1'b1);
    check("t4_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
    check("t4_ovr", {31'h0, ovr}, 32'h0);
    check("t4_cmd", {8'h0, cmd}, 32'h00445566);
    cycle(1'b0, 8'h00, 1'b1);

    // Byte arriving on the last cycle of the window wins; window restarts.
    tmo_seen = 0;
    send(8'h77); idle(TMO_CYC - 1);
    send(8'h88); idle(TMO_CYC - 1);
    check("t5_no_tmo", tmo_seen, 0);
    idle(1);
    check("t5_tmo_after_restart", tmo_seen, 1);

    // Reset in the middle of a frame.
    send(8'h99);
    do_reset();
    send(8'hDE); send(8'hAD); send(8'hBE);
    check("t6_cmd", {8'h0, cmd}, 32'h00DEADBE);
    check("t6_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);

    // Randomized traffic: sparse or bursty bytes, occasional acknowledges and long gaps.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        idle($urandom_range(TMO_CYC - 3, TMO_CYC + 3));
      end else begin
        cycle($urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
